// File: rtl/seq_det_sched.sv
// Shared "001" serial detector time-multiplexed across four requesting channels.
// Define SEQ_DET_FIXED_PRIO_EN to replace round-robin arbitration with fixed lowest-index priority.
module seq_det_sched #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       bit_in,
  input  logic [LEN_W-1:0] burst_len,
  output logic [3:0]       grant,
  output logic             busy,
  output logic             det,
  output logic             done,
  output logic [1:0]       done_ch,
  output logic             aborted,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int unsigned N_CH = 4;
  localparam int unsigned CH_W = 2;
  localparam int unsigned ZR_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [ZR_W-1:0]  ZR_ARMED  = ZR_W'(2);
  localparam logic [N_CH-1:0]  GRANT_CH0 = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_idx;
  logic [ZR_W-1:0]   zero_run;   // consecutive zeros since last 1, saturating at 2
  logic              win_vld_c;
  logic [CH_W-1:0]   win_ch_c;

`ifdef SEQ_DET_FIXED_PRIO_EN
  // Lowest-index requester wins; no rotation state.
  always_comb begin
    win_vld_c = 1'b0;
    win_ch_c  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!win_vld_c && req[CH_W'(i)]) begin
        win_vld_c = 1'b1;
        win_ch_c  = CH_W'(i);
      end
    end
  end
`else
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] idx_c;

  // Search begins at the channel after the one last served, wrapping mod 4.
  always_comb begin
    win_vld_c = 1'b0;
    win_ch_c  = '0;
    idx_c     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx_c = rr_ptr + CH_W'(i);
      if (!win_vld_c && req[idx_c]) begin
        win_vld_c = 1'b1;
        win_ch_c  = idx_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && win_vld_c) begin
      rr_ptr <= win_ch_c + CH_W'(1);
    end
  end
`endif

  // Burst sequencing, detector history and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      len_q    <= '0;
      bit_idx  <= '0;
      zero_run <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      det      <= 1'b0;
      done     <= 1'b0;
      done_ch  <= '0;
      aborted  <= 1'b0;
      hit_cnt  <= '0;
    end else begin
      det     <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld_c) begin
            state    <= RUN;
            ch       <= win_ch_c;
            len_q    <= burst_len;
            bit_idx  <= '0;
            zero_run <= '0;
            grant    <= GRANT_CH0 << win_ch_c;
            busy     <= 1'b1;
            hit_cnt  <= '0;
          end
        end
        RUN: begin
          if (!req[ch]) begin
            // Owner withdrew: end early without consuming this cycle's bit.
            state   <= DONE;
            done    <= 1'b1;
            done_ch <= ch;
            aborted <= 1'b1;
          end else begin
            if (bit_in[ch]) begin
              if (zero_run == ZR_ARMED) begin
                det <= 1'b1;
                if (hit_cnt != CNT_MAX) begin
                  hit_cnt <= hit_cnt + CNT_W'(1);
                end
              end
              zero_run <= '0;
            end else if (zero_run != ZR_ARMED) begin
              zero_run <= zero_run + ZR_W'(1);
            end
            bit_idx <= bit_idx + LEN_W'(1);
            if (bit_idx == len_q) begin
              state   <= DONE;
              done    <= 1'b1;
              done_ch <= ch;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: transaction-level reference model checked every cycle,
// directed bursts with literal expectations, then randomized traffic with async resets.
module tb_seq_det_sched;

  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       bit_in;
  logic [LEN_W-1:0] burst_len;

  logic [3:0] grant,  grant2;
  logic       busy,   busy2;
  logic       det,    det2;
  logic       done,   done2;
  logic [1:0] done_ch, done_ch2;
  logic       aborted, aborted2;
  logic [3:0] hit_cnt;
  logic [1:0] hit_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  seq_det_sched #(.CNT_W(4), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .burst_len(burst_len),
    .grant(grant), .busy(busy), .det(det), .done(done), .done_ch(done_ch),
    .aborted(aborted), .hit_cnt(hit_cnt)
  );

  seq_det_sched #(.CNT_W(2), .LEN_W(LEN_W)) u_dut_w2 (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .burst_len(burst_len),
    .grant(grant2), .busy(busy2), .det(det2), .done(done2), .done_ch(done_ch2),
    .aborted(aborted2), .hit_cnt(hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- reference model ----------------
  int         m_state;      // 0 idle, 1 running a burst, 2 reporting completion
  int         last_srv;
  int         m_ch, m_len, m_cnt, m_n;
  bit         seq_q[$];     // bits consumed in the current burst
  logic [3:0] e_grant;
  logic       e_busy, e_det, e_done, e_ab;
  int         e_dch;

  // Number of "1 after >=2 zeros" matches in the whole consumed sequence.
  function automatic int matches_in_seq();
    int z = 0;
    int n = 0;
    foreach (seq_q[i]) begin
      if (seq_q[i] == 1'b0) z++;
      else begin
        if (z >= 2) n++;
        z = 0;
      end
    end
    return n;
  endfunction

  function automatic int pick_winner(input logic [3:0] r, input int last);
    int c;
`ifdef SEQ_DET_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
    for (int k = 0; k < 4; k++) begin
      c = (last + 1 + k) % 4;
      if (r[c]) return c;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; last_srv = -1; m_cnt = 0; m_ch = 0; m_len = 0;
      e_grant = 4'd0; e_busy = 1'b0; e_det = 1'b0; e_done = 1'b0; e_ab = 1'b0; e_dch = 0;
      seq_q.delete();
    end else begin
      e_det = 1'b0; e_done = 1'b0; e_ab = 1'b0;
      case (m_state)
        0: if (req != 4'd0) begin
          m_ch = pick_winner(req, last_srv);
          last_srv = m_ch;
          m_len = int'(burst_len) + 1;
          seq_q.delete();
          m_cnt = 0;
          e_grant = 4'(1 << m_ch);
          e_busy = 1'b1;
          m_state = 1;
        end
        1: if (!req[m_ch]) begin
          e_done = 1'b1; e_ab = 1'b1; e_dch = m_ch; m_state = 2;
        end else begin
          seq_q.push_back(bit_in[m_ch]);
          m_n = matches_in_seq();
          e_det = (m_n > m_cnt);
          m_cnt = m_n;
          if (seq_q.size() == m_len) begin
            e_done = 1'b1; e_dch = m_ch; m_state = 2;
          end
        end
        default: begin
          e_grant = 4'd0; e_busy = 1'b0; m_state = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant",   int'(grant),   int'(e_grant));
      chk("busy",    int'(busy),    int'(e_busy));
      chk("det",     int'(det),     int'(e_det));
      chk("done",    int'(done),    int'(e_done));
      chk("aborted", int'(aborted), int'(e_ab));
      chk("hit_cnt", int'(hit_cnt), imin(m_cnt, 15));
      if (e_done) chk("done_ch", int'(done_ch), e_dch);
      chk("w2_grant",   int'(grant2),   int'(e_grant));
      chk("w2_det",     int'(det2),     int'(e_det));
      chk("w2_done",    int'(done2),    int'(e_done));
      chk("w2_hit_cnt", int'(hit_cnt2), imin(m_cnt, 3));
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic wait_busy(input string nm);
    int w = 0;
    do begin @(negedge clk); w++; end while (!busy && w < 20);
    if (!busy) chk({nm, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    do begin @(negedge clk); w++; end while (busy && w < 40);
    if (busy) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  // Drives one burst on channel c; drop_at = bits consumed before req falls (-1: never).
  task automatic burst(input int c, input int len, input logic [15:0] bits, input int drop_at,
                       output int dets, output int run_cyc, output logic [3:0] g,
                       output logic dn, output logic ab, output int dch, output int hc,
                       output logic det_at_done);
    dets = 0; run_cyc = 0; dn = 1'b0; ab = 1'b0; dch = 0; hc = 0; det_at_done = 1'b0;
    burst_len = LEN_W'(len);
    req[c] = 1'b1;
    wait_busy("burst");
    g = grant;
    for (int k = 0; k <= len && busy; k++) begin
      if (k == drop_at) req[c] = 1'b0;
      else bit_in[c] = bits[k];
      run_cyc++;
      @(negedge clk);
      if (det) dets++;
      if (done) begin
        dn = 1'b1; ab = aborted; dch = int'(done_ch); hc = int'(hit_cnt); det_at_done = det;
        break;
      end
    end
    req[c] = 1'b0;
    bit_in = 4'd0;
    @(negedge clk);
  endtask

  int         d_dets, d_run, d_dch, d_hc;
  logic [3:0] d_g;
  logic       d_dn, d_ab, d_det_done;
  logic [3:0] rr_exp [5];

  initial begin
    rst = 1'b1; req = 4'd0; bit_in = 4'd0; burst_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant",   int'(grant),   0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    chk("rst_done",    int'(done),    0);
    chk("rst_det",     int'(det),     0);
    rst = 1'b0;
    chk_en = 1'b1;

    // All channels requesting continuously.
`ifdef SEQ_DET_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    req = 4'hF; burst_len = '0;
    for (int b = 0; b < 5; b++) begin
      wait_busy("rr");
      chk("rr_grant", int'(grant), int'(rr_exp[b]));
      wait_idle("rr");
    end
    req = 4'd0;
    repeat (2) @(negedge clk);

    // ch0, 0,0,1,0,0,0,1
    burst(0, 6, 16'h0044, -1, d_dets, d_run, d_g, d_dn, d_ab, d_dch, d_hc, d_det_done);
    chk("b0_grant", int'(d_g), 1);
    chk("b0_run_cycles", d_run, 7);
    chk("b0_dets", d_dets, 2);
    chk("b0_done", int'(d_dn), 1);
    chk("b0_aborted", int'(d_ab), 0);
    chk("b0_done_ch", d_dch, 0);
    chk("b0_hit_cnt", d_hc, 2);

    // ch2, "001" x5 then 0, 16 bits; narrow instance saturates
    burst(2, 15, 16'h4924, -1, d_dets, d_run, d_g, d_dn, d_ab, d_dch, d_hc, d_det_done);
    chk("b2_grant", int'(d_g), 4);
    chk("b2_hit_cnt", d_hc, 5);
    chk("b2_w2_hit_cnt", int'(hit_cnt2), 3);
    chk("b2_done_ch", d_dch, 2);

    // ch1, req drops after 4 zeros; unsampled 5th bit would have matched
    burst(1, 9, 16'h0010, 4, d_dets, d_run, d_g, d_dn, d_ab, d_dch, d_hc, d_det_done);
    chk("b1_run_cycles", d_run, 5);
    chk("b1_aborted", int'(d_ab), 1);
    chk("b1_done_ch", d_dch, 1);
    chk("b1_hit_cnt", d_hc, 0);

    // ch3, final bit completes the match
    burst(3, 2, 16'h0004, -1, d_dets, d_run, d_g, d_dn, d_ab, d_dch, d_hc, d_det_done);
    chk("b3_det_with_done", int'(d_det_done), 1);
    chk("b3_hit_cnt", d_hc, 1);

    // Serve ch1, then reset in the middle of a ch2 burst.
    burst(1, 0, 16'h0000, -1, d_dets, d_run, d_g, d_dn, d_ab, d_dch, d_hc, d_det_done);
    burst_len = 4'd15; bit_in = 4'd0; req[2] = 1'b1;
    wait_busy("rst_mid");
    bit_in[2] = 1'b0; @(negedge clk);
    bit_in[2] = 1'b0; @(negedge clk);
    bit_in[2] = 1'b1; @(negedge clk);
    bit_in[2] = 1'b0;
    chk("rm_hit_before", int'(hit_cnt), 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_grant", int'(grant), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_hit_cnt", int'(hit_cnt), 0);
    chk("rm_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'hF;
    wait_busy("rst_after");
    chk("rm_next_grant", int'(grant), 1);
    req = 4'd0;
    wait_idle("rst_after");

    // Randomized traffic with occasional async reset.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      bit_in = 4'($urandom);
      burst_len = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    req = 4'd0;
    repeat (25) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
